// File: rtl/aes_pkg.sv
// Shared AES definitions: round-type encodings for the round datapath,
// the AES-128 round count and the GF(2^8) multiply-by-2 helper.
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    RT_NONE  = 2'd0,
    RT_INIT  = 2'd1,
    RT_MAIN  = 2'd2,
    RT_FINAL = 2'd3
  } round_type_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: loads 0x01 at the start of a block and doubles
// in GF(2^8) on every key-expansion step.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] rcon
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (load) begin
      rcon_d = 8'h01;
    end else if (advance) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcon_q <= 8'h00;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the state and round-key
// registers and steps an external combinational round datapath.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [1:0]   round_type,
  output logic [3:0]   round_idx,
  output logic [7:0]   rcon,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  input  logic [127:0] dp_result,
  input  logic [127:0] dp_next_key
);

  // Last round index that still runs a full MixColumns round.
  localparam logic [3:0] LAST_MAIN = 4'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] out_q, out_d;
  logic [3:0]   idx_q, idx_d;
  logic         rcon_load;
  logic         rcon_adv;
  logic [7:0]   rcon_cur;

  aes_rcon_gen u_rcon_gen (
    .clk     (clk),
    .rst_n   (reset_n),
    .load    (rcon_load),
    .advance (rcon_adv),
    .rcon    (rcon_cur)
  );

  // IDLE is entered asynchronously by reset, so gate acceptance on reset_n.
  assign in_ready  = reset_n && (fsm_q == S_IDLE);
  assign out_valid = (fsm_q == S_DONE);
  assign busy      = (fsm_q == S_INIT) || (fsm_q == S_ROUND) || (fsm_q == S_FINAL);
  assign out_block = out_q;
  assign round_idx = idx_q;
  assign dp_state  = state_q;
  assign dp_key    = key_q;

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    key_d      = key_q;
    out_d      = out_q;
    idx_d      = idx_q;
    rcon_load  = 1'b0;
    rcon_adv   = 1'b0;
    round_type = RT_NONE;
    rcon       = 8'h00;
    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d   = in_block;
          key_d     = in_key;
          idx_d     = 4'd0;
          rcon_load = 1'b1;
          fsm_d     = S_INIT;
        end
      end
      S_INIT: begin
        round_type = RT_INIT;
        rcon       = rcon_cur;
        state_d    = dp_result;
        key_d      = dp_next_key;
        idx_d      = 4'd1;
        rcon_adv   = 1'b1;
        fsm_d      = S_ROUND;
      end
      S_ROUND: begin
        round_type = RT_MAIN;
        rcon       = rcon_cur;
        state_d    = dp_result;
        key_d      = dp_next_key;
        idx_d      = idx_q + 4'd1;
        rcon_adv   = 1'b1;
        if (idx_q == LAST_MAIN) begin
          fsm_d = S_FINAL;
        end
      end
      S_FINAL: begin
        // No key expansion follows the last round, so dp_next_key is unused here.
        round_type = RT_FINAL;
        out_d      = dp_result;
        fsm_d      = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          fsm_d = S_IDLE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      key_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES round datapath
// wired to the dp_* ports; checks FIPS-197 vectors, sequencing, backpressure and reset.
module tb_aes_round_ctrl;

  localparam logic [127:0] B_BLK = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C_BLK = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;
  logic [1:0]   round_type;
  logic [3:0]   round_idx;
  logic [7:0]   rcon;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic [127:0] dp_result;
  logic [127:0] dp_next_key;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;

  logic [7:0] rcon_tab [11] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                8'h40, 8'h80, 8'h1b, 8'h36, 8'h00};

  aes_round_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_block    (in_block),
    .in_key      (in_key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_block   (out_block),
    .busy        (busy),
    .round_type  (round_type),
    .round_idx   (round_idx),
    .rcon        (rcon),
    .dp_state    (dp_state),
    .dp_key      (dp_key),
    .dp_result   (dp_result),
    .dp_next_key (dp_next_key)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- behavioural round datapath ----------------
  function automatic logic [7:0] gm2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gm2(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (a^2 * a^4 * ... * a^128), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int r, c, src;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      r   = i % 4;
      c   = i / 4;
      src = r + 4 * ((c + r) % 4);
      o[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm2(a0) ^ gm2(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gm2(a1) ^ gm2(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gm2(a2) ^ gm2(a3) ^ a3;
      o[103-32*c -: 8] = gm2(a0) ^ a0 ^ a1 ^ a2 ^ gm2(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb begin
    dp_result = '0;
    case (round_type)
      2'd1:    dp_result = dp_state ^ dp_key;
      2'd2:    dp_result = mix_cols(sub_shift(dp_state)) ^ dp_key;
      2'd3:    dp_result = sub_shift(dp_state) ^ dp_key;
      default: dp_result = '0;
    endcase
    dp_next_key = expand_key(dp_key, rcon);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer a block from a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [127:0] blk, input logic [127:0] key, output int acc);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_block = blk;
    in_key   = key;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 128'(t < 40), 128'(1));
    @(negedge clk);
    acc      = edge_cnt;
    in_valid = 1'b0;
    in_block = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_out(input int acc, input logic [127:0] exp, input string tag);
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_out_wait"}, 128'(t < 40), 128'(1));
    chk({tag, "_latency"}, 128'(edge_cnt - acc), 128'(11));
    chk({tag, "_out_block"}, out_block, exp);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_round_type"}, 128'(round_type), 128'(0));
    chk({tag, "_round_idx"}, 128'(round_idx), 128'(0));
    chk({tag, "_rcon"}, 128'(rcon), 128'(0));
    chk({tag, "_dp_state"}, dp_state, 128'(0));
    chk({tag, "_dp_key"}, dp_key, 128'(0));
    chk({tag, "_out_block"}, out_block, 128'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    int acc2;
    int t;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    in_key    = '0;
    out_ready = 1'b0;

    // Reset state, before and after the first clock edges.
    #2;
    check_all_zero("rst_t0");
    repeat (3) @(negedge clk);
    check_all_zero("rst_held");
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);

    // App. B with a full sequencing trace; out_ready held low.
    send(B_BLK, B_KEY, acc);
    chk("b_init_state", dp_state, B_BLK);
    chk("b_init_key", dp_key, B_KEY);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("trace%0d_round_type", i), 128'(round_type),
          128'((i == 0) ? 1 : ((i == 10) ? 3 : 2)));
      chk($sformatf("trace%0d_round_idx", i), 128'(round_idx), 128'(i));
      chk($sformatf("trace%0d_rcon", i), 128'(rcon), 128'(rcon_tab[i]));
      chk($sformatf("trace%0d_busy", i), 128'(busy), 128'(1));
      chk($sformatf("trace%0d_out_valid", i), 128'(out_valid), 128'(0));
      @(negedge clk);
    end
    chk("b_out_valid", 128'(out_valid), 128'(1));
    chk("b_latency", 128'(edge_cnt - acc), 128'(11));
    chk("b_out_block", out_block, B_OUT);

    // Backpressure: DONE held, new data offered and ignored.
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      in_block = C_BLK;
      in_key   = C_KEY;
      @(negedge clk);
      chk($sformatf("bp%0d_out_valid", i), 128'(out_valid), 128'(1));
      chk($sformatf("bp%0d_in_ready", i), 128'(in_ready), 128'(0));
      chk($sformatf("bp%0d_out_block", i), out_block, B_OUT);
      chk($sformatf("bp%0d_dp_key", i), dp_key, B_K10);
      chk($sformatf("bp%0d_round_type", i), 128'(round_type), 128'(0));
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_out_valid", 128'(out_valid), 128'(0));
    chk("hs_in_ready", 128'(in_ready), 128'(1));
    chk("hs_out_block_kept", out_block, B_OUT);
    chk("hs_key_not_captured", dp_key, B_K10);
    @(negedge clk);
    acc      = edge_cnt;
    in_valid = 1'b0;
    chk("c_accept_round_type", 128'(round_type), 128'(1));
    chk("c_accept_state", dp_state, C_BLK);
    chk("c_accept_key", dp_key, C_KEY);
    wait_out(acc, C_OUT, "c1");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("c1_released", 128'(out_valid), 128'(0));

    // Reset asserted between edges during round 5.
    send(B_BLK, B_KEY, acc);
    repeat (5) @(negedge clk);
    chk("mid_round_idx", 128'(round_idx), 128'(5));
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_hold%0d_out_valid", i), 128'(out_valid), 128'(0));
      chk($sformatf("rst_hold%0d_in_ready", i), 128'(in_ready), 128'(0));
    end
    reset_n = 1'b1;
    #1;
    chk("rst_release_in_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_idle%0d_out_valid", i), 128'(out_valid), 128'(0));
    end
    send(B_BLK, B_KEY, acc);
    wait_out(acc, B_OUT, "b_after_rst");
    out_ready = 1'b1;
    @(negedge clk);

    // Back-to-back with out_ready tied high: accept E0, out handshake E12, next accept E13.
    send(B_BLK, B_KEY, acc);
    in_valid = 1'b1;
    in_block = C_BLK;
    in_key   = C_KEY;
    wait_out(acc, B_OUT, "b2b_first");
    t = 0;
    while (round_type != 2'd1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_second_accept_wait", 128'(t < 40), 128'(1));
    acc2     = edge_cnt;
    in_valid = 1'b0;
    chk("b2b_accept_spacing", 128'(acc2 - acc), 128'(13));
    wait_out(acc2, C_OUT, "b2b_second");
    @(negedge clk);
    chk("b2b_end_out_valid", 128'(out_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
